// File: rtl/result_broadcast_arbiter.sv
// result_broadcast_arbiter
// Collects tagged results from UNITS execution units. Each unit has a small FIFO.
// One non-empty FIFO is granted per cycle in round-robin order. The winning head
// entry is sent on a single registered operand-update broadcast, which every
// reservation station samples.
module result_broadcast_arbiter #(
  parameter int UNITS       = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [UNITS-1:0]                    result_valid,
  output logic [UNITS-1:0]                    result_ready,
  input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]   result_rs_id_in,
  input  logic [UNITS-1:0][31:0]              result_value_in,
  output logic                                operand_valid,
  output logic [RS_ID_WIDTH-1:0]              update_op_rs_id_out,
  output logic [31:0]                         update_op_value_out
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int RR_W    = $clog2(UNITS);
  localparam int ENTRY_W = RS_ID_WIDTH + 32;

  // Per-unit FIFO status, seen by the arbiter and the producers.
  logic [UNITS-1:0]              fifo_empty;
  logic [UNITS-1:0]              fifo_full;
  logic [UNITS-1:0]              fifo_push;
  logic [UNITS-1:0]              fifo_pop;
  logic [UNITS-1:0][ENTRY_W-1:0] fifo_head;

  // Round-robin state and grant decode.
  logic [RR_W-1:0] rr_ptr_q;
  logic [RR_W-1:0] rr_ptr_d;
  logic [RR_W-1:0] grant_idx;
  logic            grant_found;

  // Broadcast output registers.
  logic                   operand_valid_q;
  logic                   operand_valid_d;
  logic [RS_ID_WIDTH-1:0] update_op_rs_id_q;
  logic [RS_ID_WIDTH-1:0] update_op_rs_id_d;
  logic [31:0]            update_op_value_q;
  logic [31:0]            update_op_value_d;

  genvar gi;
  generate
    for (gi = 0; gi < UNITS; gi++) begin : g_fifo
      logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]   wr_ptr_q;
      logic [PTR_W-1:0]   wr_ptr_d;
      logic [PTR_W-1:0]   rd_ptr_q;
      logic [PTR_W-1:0]   rd_ptr_d;
      logic [CNT_W-1:0]   count_q;
      logic [CNT_W-1:0]   count_d;

      // Ready comes only from the registered count. A full FIFO refuses a push,
      // even in a cycle where it is also being popped.
      assign fifo_full[gi]    = (count_q == CNT_W'(FIFO_DEPTH));
      assign fifo_empty[gi]   = (count_q == '0);
      assign result_ready[gi] = ~fifo_full[gi];
      assign fifo_push[gi]    = result_valid[gi] & ~fifo_full[gi];
      assign fifo_head[gi]    = mem_q[rd_ptr_q];

      // Next-state pointers and occupancy. The pointers wrap naturally at the power-of-two depth.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push[gi]) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop[gi]) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_push[gi], fifo_pop[gi]})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end

      // Pointer and count registers. Reset discards any buffered entries.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Entry storage. The contents are don't-care while the count says empty, so the storage has no reset.
      always_ff @(posedge clk) begin
        if (fifo_push[gi]) begin
          mem_q[wr_ptr_q] <= {result_rs_id_in[gi], result_value_in[gi]};
        end
      end
    end
  endgenerate

  // Round-robin scan from rr_ptr. The first non-empty FIFO wins.
  always_comb begin
    int               idx;
    logic [RR_W-1:0]  cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < UNITS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= UNITS) begin
        idx = idx - UNITS;
      end
      cand = RR_W'(idx);
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot pop for the granted FIFO.
  always_comb begin
    fifo_pop = '0;
    if (grant_found) begin
      fifo_pop[grant_idx] = 1'b1;
    end
  end

  // Broadcast and pointer next-state. The tag and value hold their last values when idle.
  always_comb begin
    operand_valid_d   = 1'b0;
    update_op_rs_id_d = update_op_rs_id_q;
    update_op_value_d = update_op_value_q;
    rr_ptr_d          = rr_ptr_q;
    if (grant_found) begin
      operand_valid_d   = 1'b1;
      update_op_rs_id_d = fifo_head[grant_idx][ENTRY_W-1:32];
      update_op_value_d = fifo_head[grant_idx][31:0];
      if (grant_idx == RR_W'(UNITS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + RR_W'(1);
      end
    end
  end

  // Registered broadcast. Reset drops operand_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_valid_q   <= 1'b0;
      update_op_rs_id_q <= '0;
      update_op_value_q <= '0;
      rr_ptr_q          <= '0;
    end else begin
      operand_valid_q   <= operand_valid_d;
      update_op_rs_id_q <= update_op_rs_id_d;
      update_op_value_q <= update_op_value_d;
      rr_ptr_q          <= rr_ptr_d;
    end
  end

  assign operand_valid       = operand_valid_q;
  assign update_op_rs_id_out = update_op_rs_id_q;
  assign update_op_value_out = update_op_value_q;

endmodule
